// File: rtl/stream_dispatch_pkg.sv
// Shared definitions for the stream dispatcher.
// The statistics types are consumed only when STREAM_DISPATCH_STATS_EN is defined.
package stream_dispatch_pkg;

    // Width of each per-port dispatch statistics counter.
    localparam int STATS_W = 32;

    // One per-port wrapping dispatch counter.
    typedef logic [STATS_W-1:0] dispatch_stats_t;

    // Value the sticky credit-error flag takes once an overflow has been seen.
    localparam logic CREDIT_ERR_SET = 1'b1;

endpackage

// File: rtl/stream_dispatch_credit_counter.sv
// Per-port credit counter for the stream dispatcher.
// Starts full, decrements on dispatch and increments on completion. When both
// events hit in the same cycle the count is unchanged. A completion on a full
// counter saturates and raises a one-cycle overflow pulse.
module stream_dispatch_credit_counter #(
    parameter int CREDITS      = 4,
    parameter int CREDIT_WIDTH = $clog2(CREDITS + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    dispatch_i,
    input  logic                    complete_i,
    output logic [CREDIT_WIDTH-1:0] count_o,
    output logic                    nonzero_o,
    output logic                    overflow_o
);

    typedef logic [CREDIT_WIDTH-1:0] credit_t;

    localparam credit_t FULL = credit_t'(CREDITS);
    localparam credit_t ONE  = credit_t'(1);

    credit_t count_q;
    credit_t count_d;

    // Next credit value: net effect of dispatch and completion, saturating at full.
    always_comb begin
        count_d    = count_q;
        overflow_o = 1'b0;
        if (dispatch_i && !complete_i) begin
            count_d = count_q - ONE;
        end else if (complete_i && !dispatch_i) begin
            if (count_q == FULL) begin
                overflow_o = 1'b1;
            end else begin
                count_d = count_q + ONE;
            end
        end
    end

    // Credit register, refilled to full on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= FULL;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign nonzero_o = (count_q != '0);

endmodule

// File: rtl/stream_dispatch.sv
// Round-robin credit-based stream dispatcher.
// Picks a destination port for each id-less input transfer among ports that are
// enabled and hold credit, and emits payload plus id on a registered output.
// Optional macro STREAM_DISPATCH_STATS_EN adds per-port wrapping dispatch counts.
module stream_dispatch
    import stream_dispatch_pkg::*;
#(
    parameter int PORTS        = 2,
    parameter int ID_WIDTH     = $clog2(PORTS),
    parameter int CREDITS      = 4,
    parameter int CREDIT_WIDTH = $clog2(CREDITS + 1),
    parameter int DATA_W       = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          stream_in_valid_i,
    input  logic [DATA_W-1:0]             stream_in_data_i,
    output logic                          stream_in_ready_o,
    output logic                          stream_out_valid_o,
    output logic [DATA_W-1:0]             stream_out_data_o,
    input  logic                          stream_out_ready_i,
    output logic [ID_WIDTH-1:0]           stream_out_id_o,
    input  logic [PORTS-1:0]              port_enable_i,
    input  logic [PORTS-1:0]              port_complete_i,
    output logic [PORTS*CREDIT_WIDTH-1:0] port_credit_o,
`ifdef STREAM_DISPATCH_STATS_EN
    output logic [PORTS*STATS_W-1:0]      dispatch_count_o,
`endif
    output logic                          credit_error_o
);

    typedef logic [ID_WIDTH-1:0]     index_t;
    typedef logic [CREDIT_WIDTH-1:0] credit_t;

    if (PORTS < 2) begin : g_bad_ports
        $error("stream_dispatch: PORTS must be greater than 1");
    end
    if (CREDITS < 1) begin : g_bad_credits
        $error("stream_dispatch: CREDITS must be at least 1");
    end

    logic [PORTS-1:0] eligible;
    logic [PORTS-1:0] nonzero;
    logic [PORTS-1:0] overflow;
    logic [PORTS-1:0] dispatch;
    logic             grant_found;
    index_t           grant_idx;
    logic             accept;

    index_t           rr_q;
    index_t           rr_d;
    logic             out_valid_q;
    index_t           out_id_q;
    logic [DATA_W-1:0] out_data_q;
    logic             credit_error_q;

    assign eligible = port_enable_i & nonzero;

    // Grant the first eligible port at or above the rr pointer, wrapping around.
    always_comb begin
        int     p;
        index_t pi;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < PORTS; k++) begin
            p = int'(rr_q) + k;
            if (p >= PORTS) begin
                p = p - PORTS;
            end
            pi = index_t'(p);
            if (!grant_found && eligible[pi]) begin
                grant_found = 1'b1;
                grant_idx   = pi;
            end
        end
    end

    // Ready needs an eligible port and room in the output register; held low in reset.
    assign stream_in_ready_o = rst_ni && grant_found && (!out_valid_q || stream_out_ready_i);
    assign accept            = stream_in_valid_i && stream_in_ready_o;

    // Pointer advances past the granted port only when a transfer is accepted.
    always_comb begin
        rr_d = rr_q;
        if (accept) begin
            rr_d = (grant_idx == index_t'(PORTS - 1)) ? '0 : grant_idx + index_t'(1);
        end
    end

    // Control state: rr pointer, output valid/id and sticky credit error.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q           <= '0;
            out_valid_q    <= 1'b0;
            out_id_q       <= '0;
            credit_error_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
            if (accept) begin
                out_valid_q <= 1'b1;
                out_id_q    <= grant_idx;
            end else if (stream_out_ready_i) begin
                out_valid_q <= 1'b0;
            end
            if (|overflow) begin
                credit_error_q <= CREDIT_ERR_SET;
            end
        end
    end

    // Payload register; qualified by valid so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            out_data_q <= stream_in_data_i;
        end
    end

    for (genvar i = 0; i < PORTS; i++) begin : g_port
        credit_t count;

        assign dispatch[i] = accept && (grant_idx == index_t'(i));

        stream_dispatch_credit_counter #(
            .CREDITS      (CREDITS),
            .CREDIT_WIDTH (CREDIT_WIDTH)
        ) u_credit (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .dispatch_i (dispatch[i]),
            .complete_i (port_complete_i[i]),
            .count_o    (count),
            .nonzero_o  (nonzero[i]),
            .overflow_o (overflow[i])
        );

        assign port_credit_o[i*CREDIT_WIDTH +: CREDIT_WIDTH] = count;

`ifdef STREAM_DISPATCH_STATS_EN
        dispatch_stats_t stat_q;

        // Wrapping count of transfers dispatched to this port.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                stat_q <= '0;
            end else if (dispatch[i]) begin
                stat_q <= stat_q + dispatch_stats_t'(1);
            end
        end

        assign dispatch_count_o[i*STATS_W +: STATS_W] = stat_q;
`endif
    end

    assign stream_out_valid_o = out_valid_q;
    assign stream_out_data_o  = out_data_q;
    assign stream_out_id_o    = out_id_q;
    assign credit_error_o     = credit_error_q;

endmodule

// File: tb/tb_stream_dispatch.sv
// Self-checking bench for stream_dispatch (PORTS=4, CREDITS=4).
// Directed scenarios pin known ids and credits; a random phase follows.
module tb_stream_dispatch;

    localparam int PORTS   = 4;
    localparam int CREDITS = 4;
    localparam int DATA_W  = 8;
    localparam int IDW     = 2;
    localparam int CW      = 3;

    logic                  clk_i = 1'b0;
    logic                  rst_ni;
    logic                  in_valid;
    logic [DATA_W-1:0]     in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic [DATA_W-1:0]     out_data;
    logic                  out_ready;
    logic [IDW-1:0]        out_id;
    logic [PORTS-1:0]      port_enable;
    logic [PORTS-1:0]      port_complete;
    logic [PORTS*CW-1:0]   port_credit;
    logic                  credit_error;
`ifdef STREAM_DISPATCH_STATS_EN
    logic [PORTS*32-1:0]   dispatch_count;
`endif

    always #5 clk_i = ~clk_i;

    stream_dispatch #(
        .PORTS        (PORTS),
        .ID_WIDTH     (IDW),
        .CREDITS      (CREDITS),
        .CREDIT_WIDTH (CW),
        .DATA_W       (DATA_W)
    ) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .stream_in_valid_i  (in_valid),
        .stream_in_data_i   (in_data),
        .stream_in_ready_o  (in_ready),
        .stream_out_valid_o (out_valid),
        .stream_out_data_o  (out_data),
        .stream_out_ready_i (out_ready),
        .stream_out_id_o    (out_id),
        .port_enable_i      (port_enable),
        .port_complete_i    (port_complete),
        .port_credit_o      (port_credit),
`ifdef STREAM_DISPATCH_STATS_EN
        .dispatch_count_o   (dispatch_count),
`endif
        .credit_error_o     (credit_error)
    );

    // Behavioural model state
    int          m_cred [PORTS];
    int          m_rr;
    bit          m_valid;
    int          m_data;
    int          m_id;
    bit          m_err;
    longint      m_cnt  [PORTS];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int cred_of(input int p);
        return int'(port_credit[p*CW +: CW]);
    endfunction

    task automatic model_reset();
        for (int p = 0; p < PORTS; p++) begin
            m_cred[p] = CREDITS;
            m_cnt[p]  = 0;
        end
        m_rr    = 0;
        m_valid = 0;
        m_data  = 0;
        m_id    = 0;
        m_err   = 0;
    endtask

    // One clock cycle: compare DUT against model, then advance the model at the edge.
    // Entered and left at a falling clock edge with inputs already driven.
    task automatic cycle();
        int grant;
        bit any;
        bit exp_ready;
        bit acc;
        int c;
        int p;
        #1;
        if (!rst_ni) model_reset();
        any   = 0;
        grant = 0;
        if (rst_ni) begin
            for (int k = 0; k < PORTS; k++) begin
                p = (m_rr + k) % PORTS;
                if (!any && port_enable[p] && m_cred[p] > 0) begin
                    any   = 1;
                    grant = p;
                end
            end
        end
        exp_ready = rst_ni && any && (!m_valid || out_ready);
        chk("in_ready", in_ready, exp_ready);
        chk("out_valid", out_valid, m_valid);
        if (m_valid) begin
            chk("out_data", out_data, m_data);
            chk("out_id", out_id, m_id);
        end
        for (int q = 0; q < PORTS; q++) begin
            chk($sformatf("credit%0d", q), cred_of(q), m_cred[q]);
`ifdef STREAM_DISPATCH_STATS_EN
            chk($sformatf("count%0d", q), dispatch_count[q*32 +: 32], m_cnt[q] % 64'h1_0000_0000);
`endif
        end
        chk("credit_error", credit_error, m_err);
        acc = in_valid && exp_ready;
        @(posedge clk_i);
        if (!rst_ni) begin
            model_reset();
        end else begin
            for (int q = 0; q < PORTS; q++) begin
                c = m_cred[q] - ((acc && grant == q) ? 1 : 0) + (port_complete[q] ? 1 : 0);
                if (c > CREDITS) begin
                    c     = CREDITS;
                    m_err = 1;
                end
                m_cred[q] = c;
            end
            if (acc) begin
                m_valid = 1;
                m_data  = int'(in_data);
                m_id    = grant;
                m_rr    = (grant + 1) % PORTS;
                m_cnt[grant]++;
            end else if (out_ready) begin
                m_valid = 0;
            end
        end
        @(negedge clk_i);
    endtask

    initial begin
        rst_ni        = 1'b0;
        in_valid      = 1'b0;
        in_data       = '0;
        out_ready     = 1'b1;
        port_enable   = 4'hF;
        port_complete = '0;
        model_reset();
        @(negedge clk_i);
        cycle();
        cycle();

        // Reset state
        chk("rst_valid", out_valid, 0);
        chk("rst_id", out_id, 0);
        chk("rst_credits", port_credit, 12'h924);
        chk("rst_error", credit_error, 0);
        chk("rst_ready", in_ready, 0);
        rst_ni = 1'b1;

        // Round robin with all credits: ids 0,1,2,3 repeating, 16 accepts
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = DATA_W'(i + 8'h10);
            cycle();
            chk("rr_id", out_id, i % 4);
            chk("rr_data", out_data, i + 8'h10);
        end
        #1;
        chk("exhausted_ready", in_ready, 0);
        chk("exhausted_credits", port_credit, 0);
        cycle();

        // Credit return on port 2
        in_valid      = 1'b0;
        port_complete = 4'b0100;
        cycle();
        port_complete = '0;
        chk("return_credit2", cred_of(2), 1);
        in_valid = 1'b1;
        in_data  = 8'h77;
        cycle();
        chk("return_id", out_id, 2);
        chk("return_credit2_used", cred_of(2), 0);
        in_valid = 1'b0;
        cycle();

        // Refill everything, then backpressure
        port_complete = 4'hF;
        repeat (4) cycle();
        port_complete = '0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        cycle();
        chk("bp_first_id", out_id, 3);
        for (int i = 0; i < 5; i++) begin
            in_data = DATA_W'($urandom);
            cycle();
            chk("bp_data", out_data, 8'hA5);
            chk("bp_id", out_id, 3);
            chk("bp_ready", in_ready, 0);
            chk("bp_credit3", cred_of(3), 3);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        cycle();
        chk("bp_release", out_valid, 0);

        // Enable mask 0101: ids alternate 0,2; then disable port 0
        port_enable = 4'b0101;
        in_valid    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = DATA_W'(i);
            cycle();
            chk("mask_id", out_id, (i % 2) * 2);
        end
        port_enable = 4'b0100;
        cycle();
        chk("mask_disable_id", out_id, 2);
        in_valid = 1'b0;
        cycle();
        chk("disabled_keeps_credit0", cred_of(0), 2);

        // Simultaneous dispatch and complete on port 1
        port_enable   = 4'b0010;
        in_valid      = 1'b1;
        port_complete = 4'b0010;
        cycle();
        chk("simul_full_credit1", cred_of(1), 4);
        chk("simul_full_no_error", credit_error, 0);
        port_complete = '0;
        cycle();
        port_complete = 4'b0010;
        cycle();
        chk("simul_credit1", cred_of(1), 3);
        chk("simul_id", out_id, 1);

        // Overflow on port 3
        in_valid      = 1'b0;
        port_complete = 4'b1000;
        cycle();
        chk("fill_credit3", cred_of(3), 4);
        chk("fill_no_error", credit_error, 0);
        cycle();
        chk("ovf_credit3", cred_of(3), 4);
        chk("ovf_error", credit_error, 1);
        port_complete = '0;
        repeat (3) begin
            cycle();
            chk("ovf_sticky", credit_error, 1);
        end

        // Asynchronous reset with a held output transfer
        port_enable = 4'hF;
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        in_data     = 8'h3C;
        cycle();
        cycle();
        chk("pre_reset_valid", out_valid, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("areset_valid", out_valid, 0);
        chk("areset_credits", port_credit, 12'h924);
        chk("areset_error", credit_error, 0);
        chk("areset_ready", in_ready, 0);
        model_reset();
        @(negedge clk_i);
        cycle();
        rst_ni    = 1'b1;
        out_ready = 1'b1;
        cycle();
        chk("post_reset_id", out_id, 0);
        chk("post_reset_valid", out_valid, 1);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst_ni      = ($urandom_range(0, 499) != 0);
            port_enable = PORTS'($urandom);
            in_valid    = ($urandom_range(0, 3) != 0);
            in_data     = DATA_W'($urandom);
            out_ready   = ($urandom_range(0, 3) != 0);
            for (int p = 0; p < PORTS; p++) begin
                if (m_cred[p] < CREDITS)
                    port_complete[p] = ($urandom_range(0, 2) == 0);
                else
                    port_complete[p] = ($urandom_range(0, 63) == 0);
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
